// File: rtl/ice40_pll_supervisor.sv
// ice40_pll_supervisor
// Sequences an iCE40 PLL out of reset, waits for a stable lock, then
// releases the downstream reset. Lock loss in RUN restarts the sequence.
// Repeated lock timeouts end in a sticky FAIL state, which only a restart
// pulse or the asynchronous reset clears.
//
// State encoding: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
// The state register drives the 'state' output directly, so a checker can
// bind to it. Every other output is decoded from registers only. No input
// reaches an output through combinational logic.
//
// 'ready' is a level status flag and has no handshake partner. It is high
// exactly while the FSM sits in RUN.

module ice40_pll_supervisor #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  // State encoding (fixed; visible on the state output).
  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  // One counter is shared by every timed state. It is sized for the
  // longest interval.
  function automatic int f_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int MAXC = f_max3(RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Terminal counts: a state lasting N cycles ends at count N-1.
  localparam logic [CW-1:0] C_HOLD_END    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] C_STABLE_END  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] C_TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    C_MAX_RETRY   = 4'(MAX_RETRIES);

  // Registers
  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_count;
  logic [3:0]    r_retry;
  logic          r_lock_lost;

  // Next-state wires
  logic [2:0]    w_next_state;
  logic [CW-1:0] w_next_count;
  logic [3:0]    w_next_retry;
  logic          w_next_lost;
  logic          w_lock_s;

  assign w_lock_s = r_sync2;

  // Two-flop synchronizer for the raw PLL lock. The raw lock is asynchronous
  // to clk. w_lock_s lags 'locked' by two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and retry decision.
  // The counter is cleared on every state change.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_retry = r_retry;

    if (restart) begin
      // A restart wins over every other transition and starts a fresh
      // sequence.
      w_next_state = S_HOLD;
      w_next_retry = 4'd0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_count == C_HOLD_END) begin
            w_next_state = S_WAIT;
          end else begin
            w_next_count = r_count + 1'b1;
          end
        end

        S_WAIT: begin
          // Lock wins over a timeout that falls in the same cycle.
          if (w_lock_s) begin
            w_next_state = S_STABLE;
          end else if (r_count == C_TIMEOUT_END) begin
            if (r_retry == C_MAX_RETRY) begin
              w_next_state = S_FAIL;
            end else begin
              w_next_retry = r_retry + 4'd1;
              w_next_state = S_HOLD;
            end
          end else begin
            w_next_count = r_count + 1'b1;
          end
        end

        S_STABLE: begin
          // A drop on the final stable cycle still counts as a drop.
          if (!w_lock_s) begin
            w_next_state = S_WAIT;
          end else if (r_count == C_STABLE_END) begin
            w_next_state = S_RUN;
            w_next_retry = 4'd0;
          end else begin
            w_next_count = r_count + 1'b1;
          end
        end

        S_RUN: begin
          if (!w_lock_s) begin
            w_next_state = S_HOLD;
            w_next_retry = 4'd0;
          end
        end

        S_FAIL: begin
          w_next_state = S_FAIL;
        end

        default: begin
          // An unreachable encoding recovers through a fresh sequence.
          w_next_state = S_HOLD;
          w_next_retry = 4'd0;
        end
      endcase
    end

    // Every state change, and every restart, starts the count from zero.
    if (restart || (w_next_state != r_state)) begin
      w_next_count = '0;
    end
  end

  // Flag any RUN-to-HOLD move. Registering it gives a clean pulse in the
  // first HOLD cycle.
  assign w_next_lost = (r_state == S_RUN) && (w_next_state == S_HOLD);

  // FSM state, shared counter, retry count and the lock_lost pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_HOLD;
      r_count     <= '0;
      r_retry     <= 4'd0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      r_retry     <= w_next_retry;
      r_lock_lost <= w_next_lost;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    pll_resetb  = !((r_state == S_HOLD) || (r_state == S_FAIL));
    sys_resetn  = (r_state == S_RUN);
    ready       = (r_state == S_RUN);
    fail        = (r_state == S_FAIL);
    lock_lost   = r_lock_lost;
    retry_count = r_retry;
    state       = r_state;
  end

endmodule

// File: tb/tb_ice40_pll_supervisor.sv
// Testbench for ice40_pll_supervisor.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// there too, away from the edge. The reference model is phase/duration
// based: it counts how long each phase has lasted and applies the
// sequencing rules directly.

module tb_ice40_pll_supervisor;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 2;

  localparam int M_HOLD   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;

  // Clock and reset
  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic locked  = 1'b0;
  logic restart = 1'b0;

  logic       pll_resetb;
  logic       sys_resetn;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  ice40_pll_supervisor #(
    .RESET_CYCLES(RC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .MAX_RETRIES (MR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked     (locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_resetn (sys_resetn),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .state      (state)
  );

  // Reference model: current phase, cycles spent in it, retries used,
  // the expected lock_lost flag, and the last two lock samples.
  int m_phase;
  int m_elapsed;
  int m_retries;
  bit m_lost;
  bit m_pipe[$];

  function void model_reset();
    m_phase   = M_HOLD;
    m_elapsed = 0;
    m_retries = 0;
    m_lost    = 1'b0;
    m_pipe.delete();
    m_pipe.push_back(1'b0);
    m_pipe.push_back(1'b0);
  endfunction

  // Advance the model by one clock edge, given the inputs at that edge.
  function void model_edge(input bit l, input bit r);
    bit ls;
    int prev;
    ls = m_pipe[0];                 // lock as seen two edges after sampling
    void'(m_pipe.pop_front());
    m_pipe.push_back(l);
    prev = m_phase;
    m_elapsed = m_elapsed + 1;      // this cycle has now been spent in prev
    if (r) begin
      m_phase   = M_HOLD;
      m_retries = 0;
    end else begin
      case (m_phase)
        M_HOLD:   if (m_elapsed == RC) m_phase = M_WAIT;
        M_WAIT: begin
          if (ls) m_phase = M_STABLE;
          else if (m_elapsed == LT) begin
            if (m_retries == MR) m_phase = M_FAIL;
            else begin
              m_retries = m_retries + 1;
              m_phase   = M_HOLD;
            end
          end
        end
        M_STABLE: begin
          if (!ls) m_phase = M_WAIT;
          else if (m_elapsed == LS) begin
            m_phase   = M_RUN;
            m_retries = 0;
          end
        end
        M_RUN: begin
          if (!ls) begin
            m_phase   = M_HOLD;
            m_retries = 0;
          end
        end
        default: m_phase = m_phase;
      endcase
    end
    m_lost = (prev == M_RUN) && (m_phase == M_HOLD);
    if (r || (prev != m_phase)) m_elapsed = 0;
  endfunction

  // Expected output vector: {state, retry, pll_resetb, sys_resetn, ready, fail, lock_lost}
  function automatic logic [11:0] model_outs();
    logic held;
    held = (m_phase == M_HOLD) || (m_phase == M_FAIL);
    return {3'(m_phase), 4'(m_retries), !held, (m_phase == M_RUN),
            (m_phase == M_RUN), (m_phase == M_FAIL), m_lost};
  endfunction

  function automatic logic [11:0] dut_outs();
    return {state, retry_count, pll_resetb, sys_resetn, ready, fail, lock_lost};
  endfunction

  // Driver: apply inputs for one edge, step the model, then land #1 after the edge.
  task automatic cyc(input logic l, input logic r);
    locked  = l;
    restart = r;
    model_edge(l, r);
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (dut_outs() !== 12'h000)
      $display("FAIL reset_values: got %03h expected %03h", dut_outs(), 12'h000);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_outs() !== 12'h000)
      $display("FAIL reset_held: got %03h expected %03h", dut_outs(), 12'h000);
    if (dut_outs() !== 12'h000) errors++;
  endtask

  task automatic test_nominal();
    locked = 1'b0;
    release_reset();
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0);
      checks++;
      if (pll_resetb !== (i == 4)) begin
        errors++;
        $display("FAIL nominal_hold_len edge %0d: got pll_resetb=%0b expected %0b", i, pll_resetb, (i == 4));
      end
    end
    repeat (3) cyc(1'b0, 1'b0);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL nominal_wait: got state=%0d expected 1", state);
    end
    // first cyc below is edge k where locked=1 is first sampled
    for (int n = 1; n <= 11; n++) begin
      cyc(1'b1, 1'b0);
      if (n <= 10) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL nominal_early_ready edge k+%0d: got %0b expected 0", n - 1, ready);
        end
      end
    end
    checks++;
    if ({state, sys_resetn, ready} !== {3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL nominal_run: got state=%0d sys_resetn=%0b ready=%0b expected 3,1,1",
               state, sys_resetn, ready);
    end
  endtask

  task automatic test_lock_loss_run();
    cyc(1'b0, 1'b0);   // edge j: drop first sampled
    cyc(1'b0, 1'b0);
    checks++;
    if ({state, lock_lost} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL loss_still_run: got state=%0d lock_lost=%0b expected 3,0", state, lock_lost);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if ({state, lock_lost, sys_resetn, pll_resetb, retry_count} !== {3'd0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL loss_hold: got state=%0d lost=%0b sysn=%0b pllrb=%0b retry=%0d expected 0,1,0,0,0",
               state, lock_lost, sys_resetn, pll_resetb, retry_count);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL loss_pulse_width: got lock_lost=%0b expected 0", lock_lost);
    end
  endtask

  task automatic test_timeout_fail();
    cyc(1'b0, 1'b1);
    for (int e = 1; e <= 108; e++) begin
      cyc(1'b0, 1'b0);
      if (e == 35 || e == 71 || e == 107) begin
        checks++;
        if ({state, retry_count} !== {3'd1, 4'((e - 35) / 36)}) begin
          errors++;
          $display("FAIL timeout_pre edge %0d: got state=%0d retry=%0d expected 1,%0d",
                   e, state, retry_count, (e - 35) / 36);
        end
      end
      if (e == 36 || e == 72) begin
        checks++;
        if ({state, retry_count} !== {3'd0, 4'(e / 36)}) begin
          errors++;
          $display("FAIL timeout_retry edge %0d: got state=%0d retry=%0d expected 0,%0d",
                   e, state, retry_count, e / 36);
        end
      end
    end
    checks++;
    if ({state, fail, pll_resetb, retry_count} !== {3'd4, 1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL fail_entry: got state=%0d fail=%0b pllrb=%0b retry=%0d expected 4,1,0,2",
               state, fail, pll_resetb, retry_count);
    end
    repeat (10) cyc(1'b1, 1'b0);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL fail_sticky: got state=%0d expected 4", state);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if ({state, retry_count, fail} !== {3'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL fail_restart: got state=%0d retry=%0d fail=%0b expected 0,0,0",
               state, retry_count, fail);
    end
  endtask

  task automatic test_glitch_stable();
    int  n;
    bit  saw_run;
    n = 0;
    saw_run = 1'b0;
    cyc(1'b1, 1'b1);
    while (state !== 3'd2 && n < 20) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL glitch_reach_stable: got state=%0d expected 2", state);
    end
    repeat (5) cyc(1'b1, 1'b0);    // edges s+1..s+5
    repeat (2) cyc(1'b0, 1'b0);    // edges s+6, s+7
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL glitch_stable_kept: got state=%0d expected 2", state);
    end
    cyc(1'b0, 1'b0);               // edge s+8: would reach RUN, drop wins
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL glitch_drop_at_end: got state=%0d expected 1", state);
    end
    for (int i = 0; i < 10; i++) begin   // edges s+9..s+18
      cyc(1'b1, 1'b0);
      if (state === 3'd3) saw_run = 1'b1;
    end
    checks++;
    if (saw_run || state !== 3'd2) begin
      errors++;
      $display("FAIL glitch_no_early_run: got state=%0d saw_run=%0b expected 2,0", state, saw_run);
    end
    cyc(1'b1, 1'b0);               // edge s+19
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL glitch_relock_run: got state=%0d expected 3", state);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1'b0, 1'b1);
    for (int e = 1; e <= 72; e++) begin
      cyc(1'b0, (e == 72));
      if (e == 71) begin
        checks++;
        if ({state, retry_count} !== {3'd1, 4'd1}) begin
          errors++;
          $display("FAIL simul_pre: got state=%0d retry=%0d expected 1,1", state, retry_count);
        end
      end
    end
    checks++;
    if ({state, retry_count} !== {3'd0, 4'd0}) begin
      errors++;
      $display("FAIL simul_restart_timeout: got state=%0d retry=%0d expected 0,0", state, retry_count);
    end
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL simul_full_hold: got state=%0d expected 1", state);
    end
    // lock seen exactly on the timeout edge (edge 36 after restart)
    cyc(1'b0, 1'b1);
    for (int e = 1; e <= 36; e++) begin
      cyc((e >= 34), 1'b0);
      if (e == 35) begin
        checks++;
        if (state !== 3'd1) begin
          errors++;
          $display("FAIL simul_lock_pre: got state=%0d expected 1", state);
        end
      end
    end
    checks++;
    if ({state, retry_count} !== {3'd2, 4'd0}) begin
      errors++;
      $display("FAIL simul_lock_at_timeout: got state=%0d retry=%0d expected 2,0", state, retry_count);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    cyc(1'b1, 1'b1);
    while (state !== 3'd3 && n < 40) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL async_reach_run: got state=%0d expected 3", state);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (dut_outs() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset_no_edge: got %03h expected %03h", dut_outs(), 12'h000);
    end
    @(posedge clk);
    release_reset();
    for (int e = 1; e <= 6; e++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++;
        $display("FAIL async_rehold edge %0d: got %03h expected %03h", e, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_random();
    int       run_left;
    logic     l;
    logic     r;
    logic [11:0] exp_v;
    run_left = 0;
    l = locked;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        l = ~l;
        run_left = l ? $urandom_range(1, 40) : $urandom_range(1, 50);
      end
      run_left--;
      r = ($urandom_range(0, 199) == 0);
      cyc(l, r);
      exp_q.push_back(model_outs());
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_outs() !== exp_v) begin
        errors++;
        $display("FAIL random cycle %0d: got %03h expected %03h", i, dut_outs(), exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_lock_loss_run();
    test_timeout_fail();
    test_glitch_stable();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog bounds the whole run.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
